// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed wait-state fetch with load port and NOP-on-error substitution.
// Optional performance counters are enabled with the IMEM_PERF_CNT_EN macro.
module imem_responder #(
    parameter int unsigned N           = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_addr,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_instr,
    output logic         rsp_err,
    input  logic         ld_en,
    input  logic [N-1:0] ld_addr,
    input  logic [N-1:0] ld_data
`ifdef IMEM_PERF_CNT_EN
    ,
    output logic [31:0]  fetch_cnt,
    output logic [15:0]  err_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;
    localparam logic [N-1:0] NOP = N'(32'h0000_0013);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [N-1:0]  addr_q;
    logic [N-1:0]  mem [DEPTH];

    logic          req_fire;
    logic          rsp_load;
    logic [N-1:0]  rd_addr;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] ld_idx;
    logic          rd_err;
    logic [N-1:0]  rd_data;
    logic          unused_ld;

    assign req_fire = req_valid && req_ready;

    // Next-state and handshake decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !ld_en;
                if (req_valid && !ld_en) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt = WAIT;
                        cnt_nxt   = CW'(WAIT_STATES - 1);
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // With zero wait states the read happens on the accept edge, before addr_q is captured
    assign rsp_load = (state != RESP) && (state_nxt == RESP);
    assign rd_addr  = (state == IDLE) ? req_addr : addr_q;
    assign rd_idx   = rd_addr[AW+1:2];
    assign ld_idx   = ld_addr[AW+1:2];
    assign rd_err   = (rd_addr[1:0] != 2'b00) || (rd_addr[N-1:2] >= (N-2)'(DEPTH));
    // A load on the RESP-entry edge is forwarded so the in-flight fetch sees it
    assign rd_data  = (ld_en && (ld_idx == rd_idx)) ? ld_data : mem[rd_idx];

    assign unused_ld = ^{ld_addr[1:0], ld_addr[N-1:AW+2]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_instr <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rsp_valid <= (state_nxt == RESP);
            if (req_fire) begin
                addr_q <= req_addr;
            end
            if (rsp_load) begin
                rsp_err   <= rd_err;
                rsp_instr <= rd_err ? NOP : rd_data;
            end
        end
    end

    // Program array, not reset
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_idx] <= ld_data;
        end
    end

`ifdef IMEM_PERF_CNT_EN
    // Saturating fetch and error counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (req_fire && (fetch_cnt != '1)) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (rsp_valid && rsp_ready && rsp_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder (default parameters, optional perf counters).
module tb_imem_responder;

    localparam int unsigned N  = 32;
    localparam int unsigned WS = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
`ifdef IMEM_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [15:0] err_cnt;
`endif

    imem_responder #(.N(N), .DEPTH(256), .WAIT_STATES(WS)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_err   (rsp_err),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
`ifdef IMEM_PERF_CNT_EN
        ,
        .fetch_cnt (fetch_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    vec_t vecs [9];
    int   total;
    int   passed;
    int   exp_fetch;
    int   exp_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
        #1;
    endtask

    // Wait for rsp_valid; returns number of edges counted from the accept edge
    task automatic wait_rsp(output int n);
        n = 1;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp_i, input logic exp_e,
                         input string tag);
        int n;
        req_addr  = a;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_addr  = $urandom;
        exp_fetch++;
        if (exp_e) exp_err++;
        check({tag, " ready_low_in_wait"}, 32'(req_ready), 32'd0);
        wait_rsp(n);
        check({tag, " latency"}, 32'(n), 32'(WS + 1));
        check({tag, " instr"}, rsp_instr, exp_i);
        check({tag, " err"}, 32'(rsp_err), 32'(exp_e));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        check({tag, " valid_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, " ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int n;
        total = 0; passed = 0; exp_fetch = 0; exp_err = 0;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;

        vecs[0] = '{32'h0000_0004, 32'h0010_8113, 1'b0};
        vecs[1] = '{32'h0000_0000, 32'h0050_0093, 1'b0};
        vecs[2] = '{32'h0000_0002, NOP,           1'b1};
        vecs[3] = '{32'h0000_0400, NOP,           1'b1};
        vecs[4] = '{32'h0000_03FC, 32'hDEAD_BEEF, 1'b0};
        vecs[5] = '{32'h0000_0008, 32'h1234_5678, 1'b0};
        vecs[6] = '{32'h0000_000C, 32'hCAFE_F00D, 1'b0};
        vecs[7] = '{32'h0000_0401, NOP,           1'b1};
        vecs[8] = '{32'hFFFF_FFFC, NOP,           1'b1};

        // Reset state
        tick();
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_instr", rsp_instr, 32'd0);
        check("rst rsp_err", 32'(rsp_err), 32'd0);
        check("rst req_ready", 32'(req_ready), 32'd1);
        ld_en = 1'b1;
        #1;
        check("rst req_ready_ld", 32'(req_ready), 32'd0);
        ld_en = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Program load, including wrapped and low-bit-set load addresses
        load(32'h0000_0000, 32'h0050_0093);
        load(32'h0000_0004, 32'h0010_8113);
        load(32'h0000_03FC, 32'hDEAD_BEEF);
        load(32'h0000_0408, 32'h1234_5678);
        load(32'h0000_000D, 32'hCAFE_F00D);

        for (int i = 0; i < 9; i++) begin
            fetch(vecs[i].addr, vecs[i].instr, vecs[i].err, $sformatf("vec%0d", i));
        end

        // Backpressure: response holds while rsp_ready is low
        req_addr = 32'h4; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        exp_fetch++;
        wait_rsp(n);
        check("stall latency", 32'(n), 32'(WS + 1));
        for (int i = 0; i < 5; i++) begin
            check("stall valid", 32'(rsp_valid), 32'd1);
            check("stall instr", rsp_instr, 32'h0010_8113);
            check("stall ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        check("stall release valid", 32'(rsp_valid), 32'd0);
        check("stall release ready", 32'(req_ready), 32'd1);

        // Load and request together: load wins, request accepted next cycle
        ld_en = 1'b1; ld_addr = 32'h10; ld_data = 32'h0BAD_C0DE;
        req_valid = 1'b1; req_addr = 32'h10;
        #1;
        check("race ready_low", 32'(req_ready), 32'd0);
        tick();
        ld_en = 1'b0;
        #1;
        check("race still_idle", 32'(req_ready), 32'd1);
        fetch(32'h10, 32'h0BAD_C0DE, 1'b0, "race");

        // Load on the RESP-entry edge is visible; a later one is not
        load(32'h14, 32'h1111_1111);
        req_addr = 32'h14; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        exp_fetch++;
        tick();
        ld_en = 1'b1; ld_addr = 32'h14; ld_data = 32'h2222_2222;
        tick();
        ld_en = 1'b0;
        check("entry_ld valid", 32'(rsp_valid), 32'd1);
        check("entry_ld instr", rsp_instr, 32'h2222_2222);
        load(32'h14, 32'h3333_3333);
        check("late_ld hold", rsp_instr, 32'h2222_2222);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        fetch(32'h14, 32'h3333_3333, 1'b0, "late_ld");

        // Reset during WAIT discards the fetch
        req_addr = 32'h0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midrst valid", 32'(rsp_valid), 32'd0);
        check("midrst ready", 32'(req_ready), 32'd1);
        tick();
        tick();
        reset = 1'b0;
        exp_fetch = 0;
        exp_err = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst no_stale", 32'(rsp_valid), 32'd0);
        end

        // Three good fetches and one misaligned after reset
        fetch(32'h0, 32'h0050_0093, 1'b0, "post0");
        fetch(32'h4, 32'h0010_8113, 1'b0, "post1");
        fetch(32'h8, 32'h1234_5678, 1'b0, "post2");
        fetch(32'h2, NOP, 1'b1, "post3");
`ifdef IMEM_PERF_CNT_EN
        check("fetch_cnt", fetch_cnt, 32'(exp_fetch));
        check("err_cnt", 32'(err_cnt), 32'(exp_err));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
